fetch_stage_ctrl: RTL and testbench
===================================

Name: fetch_stage_ctrl

Overview:
- Consumer end of the stall interface: the fetch stage that obeys `stall`/`stall_pm` from the stall controller.
- Owns the program counter and drives the program-memory address.
- Registers the fetched instruction into the IF/ID latch.
- Latches a sticky halt state and counts stall cycles for debug.
- Sits between program memory and decode; its `if_instr[31:26]` is the opcode the stall controller decodes.

Parameters:
- ADDR_W, 8, width of PC / program-memory word address.
- INSTR_W, 32, instruction width; opcode is bits [INSTR_W-1:INSTR_W-6].
- CNT_W, 16, width of the stall-cycle counter.
- HLT_OP, 6'b010001, halt opcode.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  freeze PC this cycle (combinational from the stall controller).
- stall_pm  in  1  registered stall; hold the IF/ID latch and mark it invalid.
- jump_en  in  1  decode resolved a jump; load jump_addr.
- jump_addr  in  ADDR_W  jump target (word address).
- pm_instr  in  INSTR_W  program-memory data; combinational read of pm_addr.
- pm_addr  out  ADDR_W  equals pc.
- if_instr  out  INSTR_W  IF/ID instruction register.
- if_pc  out  ADDR_W  PC of if_instr.
- if_valid  out  1  if_instr is a fresh fetch (not a held bubble).
- halted  out  1  sticky halt flag.
- stall_cnt  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Reset (reset=0, async, any time including mid-jump or mid-halt):
  - pc=0, if_instr=0, if_pc=0, if_valid=0, halted=0, stall_cnt=0, FSM=RUN.
  - pm_addr follows pc, so it is also 0.
- FSM, two states:
  - RUN -> HALT when if_valid=1 and if_instr opcode == HLT_OP.
  - HALT is absorbing; only reset leaves it.
  - halted = (state==HALT), registered, asserted the cycle after the HLT is seen in if_instr.
- PC update in RUN, priority high to low:
  - stall=1: pc holds.
  - jump_en=1: pc <= jump_addr.
  - otherwise: pc <= pc+1, mod 2^ADDR_W; 2^ADDR_W-1 wraps to 0 with no flag.
- PC update in HALT: pc holds regardless of stall/jump_en.
- stall and jump_en together: stall wins. Decode keeps jump_en asserted until stall drops; the jump is taken on the first unstalled edge.
- IF/ID latch in RUN:
  - stall_pm=1: if_instr and if_pc hold, if_valid <= 0.
  - stall_pm=0: if_instr <= pm_instr, if_pc <= pc, if_valid <= 1.
  - Latency from pm_addr to if_instr is one cycle.
- IF/ID latch in HALT: if_instr/if_pc hold; if_valid <= 0.
- stall_cnt:
  - Increments on each edge with stall=1 in either state.
  - Saturates at 2^CNT_W-1, never wraps.
  - Not cleared by halt.
- stall_pm=1 with stall=0 is legal (trailing cycle of a load/jump stall); PC advances normally.
- No combinational path from any input to any output except pm_addr=pc, which is register-driven.

Decomposition:
- Shared package cpu_defs:
  - Opcode constants: HLT_OP, LD_OP=6'b010100, JMP opcode pattern 6'b0111xx.
  - ADDR_W / INSTR_W defaults.
  - FSM state encoding RUN=1'b0, HALT=1'b1.
- The stall controller also imports cpu_defs, so opcode values live in one place.
- One natural sub-module: pc_reg. It holds the ADDR_W register with async active-low reset and hold/load/increment select. The IF/ID latch, FSM and counter stay in the top.

Test Plan:
- Reset then 4 free-running cycles, pm_instr = 0x0000_0000+addr:
  - pm_addr goes 0,1,2,3.
  - if_instr goes 0,1,2 one cycle behind.
  - if_valid=1 from the first post-reset edge.
- Load stall, stall=1 for 1 cycle at pc=5 then stall_pm=1 the next cycle:
  - pc holds 5 for one edge, then continues to 6.
  - if_instr holds the previous word with if_valid=0 for exactly one cycle.
  - stall_cnt=1.
- jump_en=1, jump_addr=0x40 with stall=1 for 2 cycles, then stall=0:
  - pc holds for 2 edges, then becomes 0x40.
  - The next if_pc = 0x40.
- Instruction with opcode 010001 fetched:
  - halted=1 one cycle after if_valid shows it.
  - pc frozen; if_valid=0; jump_en=1 is ignored.
  - stall held at 1 by the controller makes stall_cnt keep counting.
- Wrap and saturate:
  - ADDR_W=8 with pc=0xFF and no stall: pc becomes 0x00.
  - CNT_W=4 with 20 stall cycles: stall_cnt sticks at 15.
- Reset asserted asynchronously mid-HALT, between clock edges:
  - All outputs go to reset values immediately.
  - After release, fetch restarts at address 0.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcode constants, default widths and the fetch
// FSM state encoding. Imported by the fetch stage and the stall controller
// so opcode values live in exactly one place.
package cpu_defs;

   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_INSTR_W = 32;

   localparam logic [5:0] HLT_OP  = 6'b010001;
   localparam logic [5:0] LD_OP   = 6'b010100;
   // Jumps occupy the 0111xx block; the low two bits select the jump kind.
   localparam logic [3:0] JMP_PFX = 4'b0111;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fsm_state_t;

   function automatic logic is_jmp(input logic [5:0] op);
      return (op[5:2] == JMP_PFX);
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register.
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-low reset, clears pc to 0
//   hold      - keep the current pc (highest priority)
//   load      - load load_addr (when not holding)
//   load_addr - jump target word address
//   pc        - current program counter; otherwise increments, wrapping mod 2^ADDR_W
module pc_reg
   import cpu_defs::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   output logic [ADDR_W-1:0] pc
);

   localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= '0;
      end else if (hold) begin
         pc <= pc;
      end else if (load) begin
         pc <= load_addr;
      end else begin
         pc <= pc + ONE;
      end
   end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: owns the PC, drives the program-memory address, registers the
// fetched word into the IF/ID latch, latches a sticky halt and counts stall
// cycles for debug.
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   stall     - freeze the PC this cycle
//   stall_pm  - hold the IF/ID latch and mark it invalid
//   jump_en   - load jump_addr into the PC (loses to stall)
//   jump_addr - jump target word address
//   pm_instr  - program-memory data for pm_addr
//   pm_addr   - program-memory address (= pc, register driven)
//   if_instr  - IF/ID instruction register
//   if_pc     - PC of if_instr
//   if_valid  - if_instr is a fresh fetch
//   halted    - sticky halt flag
//   stall_cnt - saturating count of cycles with stall=1
module fetch_stage_ctrl #(
   parameter int         ADDR_W  = cpu_defs::DEF_ADDR_W,
   parameter int         INSTR_W = cpu_defs::DEF_INSTR_W,
   parameter int         CNT_W   = 16,
   parameter logic [5:0] HLT_OP  = cpu_defs::HLT_OP
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               stall_pm,
   input  logic               jump_en,
   input  logic [ADDR_W-1:0]  jump_addr,
   input  logic [INSTR_W-1:0] pm_instr,
   output logic [ADDR_W-1:0]  pm_addr,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic               if_valid,
   output logic               halted,
   output logic [CNT_W-1:0]   stall_cnt
);
   import cpu_defs::*;

   fsm_state_t          state_q;
   fsm_state_t          state_d;
   logic [ADDR_W-1:0]   pc_p0;
   logic [INSTR_W-1:0]  instr_p1;
   logic [ADDR_W-1:0]   pc_p1;
   logic                vld_p1;
   logic [CNT_W-1:0]    cnt_q;
   logic                in_halt;
   logic [5:0]          opcode_p1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign in_halt   = (state_q == HALT);
   assign opcode_p1 = instr_p1[INSTR_W-1 -: 6];

   // ---- Stage p0: program counter / program-memory address ----
   pc_reg #(
      .ADDR_W (ADDR_W)
   ) u_pc (
      .clk       (clk),
      .reset     (reset),
      .hold      (stall | in_halt),
      .load      (jump_en),
      .load_addr (jump_addr),
      .pc        (pc_p0)
   );

   assign pm_addr = pc_p0;

   // ---- Stage p1: IF/ID latch ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_p1 <= '0;
         pc_p1    <= '0;
         vld_p1   <= 1'b0;
      end else if (in_halt || stall_pm) begin
         // Held word becomes a bubble for decode.
         instr_p1 <= instr_p1;
         pc_p1    <= pc_p1;
         vld_p1   <= 1'b0;
      end else begin
         instr_p1 <= pm_instr;
         pc_p1    <= pc_p0;
         vld_p1   <= 1'b1;
      end
   end

   assign if_instr = instr_p1;
   assign if_pc    = pc_p1;
   assign if_valid = vld_p1;

   // ---- Halt FSM: a valid HLT in IF/ID parks the stage until reset ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (vld_p1 && (opcode_p1 == HLT_OP)) state_d = HALT;
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase
   end

   assign halted = in_halt;

   // ---- Debug stall counter: counts in both states, sticks at all-ones ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (stall) begin
         cnt_q <= sat_inc(cnt_q);
      end
   end

   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
module tb_fetch_stage_ctrl;

   localparam int         ADDR_W  = 8;
   localparam int         INSTR_W = 32;
   localparam int         CNT_W   = 4;
   localparam logic [5:0] HLT     = 6'b010001;
   localparam logic [31:0] HLT_WORD = {HLT, 26'd0};
   localparam logic [7:0]  HLT_ADDR = 8'h10;

   logic               clk;
   logic               reset;
   logic               stall;
   logic               stall_pm;
   logic               jump_en;
   logic [ADDR_W-1:0]  jump_addr;
   logic [INSTR_W-1:0] pm_instr;
   logic [ADDR_W-1:0]  pm_addr;
   logic [INSTR_W-1:0] if_instr;
   logic [ADDR_W-1:0]  if_pc;
   logic               if_valid;
   logic               halted;
   logic [CNT_W-1:0]   stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_stage_ctrl #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W),
      .CNT_W   (CNT_W),
      .HLT_OP  (HLT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .stall_pm  (stall_pm),
      .jump_en   (jump_en),
      .jump_addr (jump_addr),
      .pm_instr  (pm_instr),
      .pm_addr   (pm_addr),
      .if_instr  (if_instr),
      .if_pc     (if_pc),
      .if_valid  (if_valid),
      .halted    (halted),
      .stall_cnt (stall_cnt)
   );

   // Program memory: word = its own address, except one HLT word.
   always_comb begin
      pm_instr = (pm_addr == HLT_ADDR) ? HLT_WORD : {24'd0, pm_addr};
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      stall     = 1'b0;
      stall_pm  = 1'b0;
      jump_en   = 1'b0;
      jump_addr = '0;
      #2;
      chk("rst_pm_addr",   32'(pm_addr),   32'h0);
      chk("rst_if_instr",  if_instr,       32'h0);
      chk("rst_if_valid",  32'(if_valid),  32'h0);
      chk("rst_halted",    32'(halted),    32'h0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Free-running fetch
      step();
      chk("run1_pm_addr",  32'(pm_addr),  32'h1);
      chk("run1_if_instr", if_instr,      32'h0);
      chk("run1_if_valid", 32'(if_valid), 32'h1);
      step();
      chk("run2_pm_addr",  32'(pm_addr),  32'h2);
      chk("run2_if_instr", if_instr,      32'h1);
      step();
      chk("run3_pm_addr",  32'(pm_addr),  32'h3);
      chk("run3_if_instr", if_instr,      32'h2);
      step();
      step();
      chk("run5_pm_addr",  32'(pm_addr),  32'h5);
      chk("run5_if_pc",    32'(if_pc),    32'h4);

      // Load stall at pc=5: stall one cycle, then stall_pm one cycle
      stall = 1'b1;
      step();
      chk("ld_hold_pc",   32'(pm_addr),   32'h5);
      chk("ld_cnt1",      32'(stall_cnt), 32'h1);
      chk("ld_if_instr",  if_instr,       32'h5);
      stall    = 1'b0;
      stall_pm = 1'b1;
      step();
      chk("ld_pc_adv",    32'(pm_addr),   32'h6);
      chk("ld_bub_instr", if_instr,       32'h5);
      chk("ld_bub_valid", 32'(if_valid),  32'h0);
      stall_pm = 1'b0;
      step();
      chk("ld_resume_valid", 32'(if_valid), 32'h1);
      chk("ld_resume_instr", if_instr,      32'h6);
      chk("ld_resume_pc",    32'(pm_addr),  32'h7);

      // Jump held under a 2-cycle stall
      jump_en   = 1'b1;
      jump_addr = 8'h40;
      stall     = 1'b1;
      step();
      chk("jmp_hold1", 32'(pm_addr), 32'h7);
      step();
      chk("jmp_hold2", 32'(pm_addr),   32'h7);
      chk("jmp_cnt3",  32'(stall_cnt), 32'h3);
      stall = 1'b0;
      step();
      chk("jmp_taken", 32'(pm_addr), 32'h40);
      jump_en = 1'b0;
      step();
      chk("jmp_if_pc",    32'(if_pc),   32'h40);
      chk("jmp_if_instr", if_instr,     32'h40);
      chk("jmp_next_pc",  32'(pm_addr), 32'h41);

      // PC wrap 0xFF -> 0x00
      jump_en   = 1'b1;
      jump_addr = 8'hFE;
      step();
      jump_en = 1'b0;
      step();
      chk("wrap_ff", 32'(pm_addr), 32'hFF);
      step();
      chk("wrap_00",    32'(pm_addr), 32'h00);
      chk("wrap_if_pc", 32'(if_pc),   32'hFF);

      // Halt
      jump_en   = 1'b1;
      jump_addr = HLT_ADDR;
      step();
      jump_en = 1'b0;
      step();
      chk("hlt_seen_instr", if_instr,      HLT_WORD);
      chk("hlt_seen_valid", 32'(if_valid), 32'h1);
      chk("hlt_not_yet",    32'(halted),   32'h0);
      step();
      chk("hlt_halted", 32'(halted),  32'h1);
      chk("hlt_pc",     32'(pm_addr), 32'h12);
      jump_en   = 1'b1;
      jump_addr = 8'h80;
      stall     = 1'b1;
      step();
      chk("hlt_pc_frozen", 32'(pm_addr),   32'h12);
      chk("hlt_valid0",    32'(if_valid),  32'h0);
      chk("hlt_hold_ins",  if_instr,       32'h11);
      chk("hlt_cnt4",      32'(stall_cnt), 32'h4);
      for (int i = 0; i < 19; i++) step();
      chk("sat_cnt15",  32'(stall_cnt), 32'hF);
      chk("hlt_pc_still", 32'(pm_addr), 32'h12);
      stall = 1'b0;
      step();
      chk("hlt_jump_ignored", 32'(pm_addr),  32'h12);
      chk("hlt_sticky",       32'(halted),   32'h1);
      chk("sat_no_wrap",      32'(stall_cnt), 32'hF);

      // Asynchronous reset between edges
      #3;
      reset = 1'b0;
      #1;
      chk("arst_pm_addr",   32'(pm_addr),   32'h0);
      chk("arst_if_instr",  if_instr,       32'h0);
      chk("arst_if_pc",     32'(if_pc),     32'h0);
      chk("arst_if_valid",  32'(if_valid),  32'h0);
      chk("arst_halted",    32'(halted),    32'h0);
      chk("arst_stall_cnt", 32'(stall_cnt), 32'h0);
      jump_en = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      step();
      chk("restart_pm_addr",  32'(pm_addr),  32'h1);
      chk("restart_if_instr", if_instr,      32'h0);
      chk("restart_valid",    32'(if_valid), 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
